// File: rtl/fpadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_arbiter
// Brief    : Round-robin two-requester front end for a pipelined FP adder,
//            with tagged in-order responses and a drain/flush mode.
// Revision : 1.0
// ============================================================================
module fpadd_arbiter #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_result,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_prio;
    logic               r_flush_block;
    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_id;
    logic [31:0]        r_add_a;
    logic [31:0]        r_add_b;
    logic [31:0]        r_rsp0_data;
    logic [31:0]        r_rsp1_data;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic               r_flush_done;

    logic               w_ready0;
    logic               w_ready1;
    logic               w_xfer0;
    logic               w_xfer1;
    logic               w_xfer;
    logic               w_next_idle;
    logic               w_flush_exit;
    logic [LATENCY-1:0] w_tag_vld_next;
    logic [LATENCY-1:0] w_tag_id_next;

    assign w_xfer0 = req0_valid & w_ready0;
    assign w_xfer1 = req1_valid & w_ready1;
    assign w_xfer  = w_xfer0 | w_xfer1;

    // w_next_idle: no tag survives the coming shift (no issue happens in DRAIN)
    generate
        if (LATENCY == 1) begin : g_tag_single
            assign w_tag_vld_next = w_xfer;
            assign w_tag_id_next  = w_xfer1;
            assign w_next_idle    = 1'b1;
        end else begin : g_tag_multi
            assign w_tag_vld_next = {r_tag_vld[LATENCY-2:0], w_xfer};
            assign w_tag_id_next  = {r_tag_id[LATENCY-2:0], w_xfer1};
            assign w_next_idle    = ~|r_tag_vld[LATENCY-2:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_flush_exit = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready0 = rst & req0_valid & (~r_prio | ~req1_valid);
                w_ready1 = rst & req1_valid & (r_prio | ~req0_valid);
                if (flush_req && !r_flush_block) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_next_idle) begin
                    w_state_next = ST_RUN;
                    w_flush_exit = 1'b1;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio        <= 1'b0;
            r_flush_block <= 1'b0;
            r_tag_vld     <= '0;
            r_tag_id      <= '0;
            r_add_a       <= '0;
            r_add_b       <= '0;
            r_rsp0_data   <= '0;
            r_rsp1_data   <= '0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_flush_done  <= 1'b0;
        end else begin
            r_tag_vld <= w_tag_vld_next;
            r_tag_id  <= w_tag_id_next;
            if (w_xfer0) begin
                r_add_a <= req0_a;
                r_add_b <= req0_b;
                r_prio  <= 1'b1;
            end else if (w_xfer1) begin
                r_add_a <= req1_a;
                r_add_b <= req1_b;
                r_prio  <= 1'b0;
            end
            r_rsp0_valid <= r_tag_vld[LATENCY-1] & ~r_tag_id[LATENCY-1];
            r_rsp1_valid <= r_tag_vld[LATENCY-1] &  r_tag_id[LATENCY-1];
            if (r_tag_vld[LATENCY-1] && !r_tag_id[LATENCY-1]) begin
                r_rsp0_data <= add_result;
            end
            if (r_tag_vld[LATENCY-1] && r_tag_id[LATENCY-1]) begin
                r_rsp1_data <= add_result;
            end
            r_flush_done <= w_flush_exit;
            // A held flush_req must drop before it can start another drain
            if (w_flush_exit) begin
                r_flush_block <= flush_req;
            end else if (!flush_req) begin
                r_flush_block <= 1'b0;
            end
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign flush_done = r_flush_done;
    assign busy       = |r_tag_vld;

endmodule
`default_nettype wire

// File: tb/tb_fpadd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpadd_arbiter
// Brief    : Directed self-checking bench for fpadd_arbiter with a float adder.
// Revision : 1.0
// ============================================================================
module tb_fpadd_arbiter;

    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic [31:0] add_a, add_b, add_result;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        flush_req = 1'b0;
    logic        flush_done, busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_edge   = 0;
    int          n_fdone  = 0;
    logic [31:0] c_num [0:20];
    int          q_id[$];
    logic [31:0] q_data[$];
    int          q_edge[$];
    logic [31:0] r_s1 = '0, r_s2 = '0;

    fpadd_arbiter #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Float <-> double repacking for normal values and zero only
    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        e = 11'(f[30:23]) - 11'd127 + 11'd1023;
        return {f[31], e, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real s;
        s = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
        return d2f($realtobits(s));
    endfunction

    // Adder stand-in: add_result matches add_a/add_b LATENCY edges later
    always @(posedge clk) begin
        r_s1 <= fadd(add_a, add_b);
        r_s2 <= r_s1;
    end
    assign add_result = r_s2;

    always @(posedge clk) n_edge <= n_edge + 1;

    // Each strobe is logged with the edge at which a requester samples it
    always @(negedge clk) begin
        if (rsp0_valid === 1'b1) begin
            q_id.push_back(0); q_data.push_back(rsp0_data); q_edge.push_back(n_edge + 1);
        end
        if (rsp1_valid === 1'b1) begin
            q_id.push_back(1); q_data.push_back(rsp1_data); q_edge.push_back(n_edge + 1);
        end
        if (flush_done === 1'b1) n_fdone++;
    end

    task automatic clear_log();
        q_id.delete(); q_data.delete(); q_edge.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (add_a !== 32'h0) begin n_fail++; $display("FAIL rst_add_a got %h want 00000000", add_a); end
        n_checks++; if (add_b !== 32'h0) begin n_fail++; $display("FAIL rst_add_b got %h want 00000000", add_b); end
        n_checks++; if (rsp0_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp0_data got %h want 00000000", rsp0_data); end
        n_checks++; if (rsp1_data !== 32'h0) begin n_fail++; $display("FAIL rst_rsp1_data got %h want 00000000", rsp1_data); end
        n_checks++; if ({rsp0_valid, rsp1_valid, flush_done, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_flags got %b want 0000", {rsp0_valid, rsp1_valid, flush_done, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        logic [31:0] a0 [0:1], b0 [0:1], a1 [0:1], b1 [0:1], e_data [0:3];
        int e_id [0:3];
        int x0, i0, i1, n;
        a0[0] = c_num[1]; b0[0] = c_num[2]; a1[0] = c_num[3]; b1[0] = c_num[4];
        a0[1] = c_num[5]; b0[1] = c_num[1]; a1[1] = c_num[8]; b1[1] = c_num[2];
        e_data[0] = 32'h40400000; e_data[1] = 32'h40E00000; e_data[2] = 32'h40C00000; e_data[3] = 32'h41200000;
        e_id[0] = 0; e_id[1] = 1; e_id[2] = 0; e_id[3] = 1;
        i0 = 0; i1 = 0;
        clear_log();
        x0 = n_edge + 1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = a0[i0 % 2]; req0_b = b0[i0 % 2];
            req1_a = a1[i1 % 2]; req1_b = b1[i1 % 2];
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL contention_grant cycle %0d got %b want %b", i,
                                   {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i % 2 == 0) i0++; else i1++;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (q_id.size() != 4) begin n_fail++; $display("FAIL contention_count got %0d want 4", q_id.size()); end
        n = (q_id.size() < 4) ? q_id.size() : 4;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (q_id[i] != e_id[i] || q_data[i] !== e_data[i] || q_edge[i] != x0 + i + 4) begin
                n_fail++; $display("FAIL contention_rsp %0d got id%0d %h edge %0d want id%0d %h edge %0d",
                                   i, q_id[i], q_data[i], q_edge[i], e_id[i], e_data[i], x0 + i + 4);
            end
        end
    endtask

    task automatic test_single();
        int x0;
        clear_log();
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", req0_ready); end
        x0 = n_edge + 1;
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
            n_fail++; $display("FAIL single_operands got %h %h want 3f800000 40000000", add_a, add_b);
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
        repeat (8) @(negedge clk);
        n_checks++;
        if (q_id.size() != 1 || q_id[0] != 0 || q_data[0] !== 32'h40400000 || q_edge[0] != x0 + 4) begin
            n_fail++; $display("FAIL single_rsp count %0d first id%0d %h edge %0d want 1 id0 40400000 edge %0d",
                               q_id.size(), (q_id.size() > 0) ? q_id[0] : -1,
                               (q_data.size() > 0) ? q_data[0] : 32'h0,
                               (q_edge.size() > 0) ? q_edge[0] : -1, x0 + 4);
        end
        n_checks++; if (rsp1_data !== 32'h41200000) begin n_fail++; $display("FAIL single_rsp1_hold got %h want 41200000", rsp1_data); end
        n_checks++; if (add_a !== 32'h3F800000) begin n_fail++; $display("FAIL single_operand_hold got %h want 3f800000", add_a); end
    endtask

    task automatic test_streaming();
        int x0, n;
        logic busy_ok;
        clear_log();
        busy_ok = 1'b1;
        x0 = n_edge + 1;
        for (int k = 1; k <= 10; k++) begin
            req1_valid = 1'b1; req1_a = c_num[k]; req1_b = c_num[1];
            #1;
            n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready beat %0d got %b want 1", k, req1_ready); end
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        req1_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL stream_busy got dropout want continuously 1"); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy_end got %b want 0", busy); end
        repeat (4) @(negedge clk);
        n_checks++; if (q_id.size() != 10) begin n_fail++; $display("FAIL stream_count got %0d want 10", q_id.size()); end
        n = (q_id.size() < 10) ? q_id.size() : 10;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (q_id[i] != 1 || q_data[i] !== c_num[i + 2] || q_edge[i] != x0 + i + 4) begin
                n_fail++; $display("FAIL stream_rsp %0d got id%0d %h edge %0d want id1 %h edge %0d",
                                   i, q_id[i], q_data[i], q_edge[i], c_num[i + 2], x0 + i + 4);
            end
        end
    endtask

    task automatic test_flush();
        int e0;
        clear_log();
        n_fdone = 0;
        e0 = n_edge + 1;
        req0_valid = 1'b1; req0_a = c_num[2]; req0_b = c_num[3];
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL flush_issue0_ready got %b want 1", req0_ready); end
        @(negedge clk);
        req0_a = c_num[4]; req0_b = c_num[4]; flush_req = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL flush_same_cycle_ready got %b want 1", req0_ready); end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) begin flush_req = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; end
            #1;
            if (j <= 3) begin
                n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
                    n_fail++; $display("FAIL flush_drain_ready cycle %0d got %b want 00", j, {req0_ready, req1_ready});
                end
            end
            n_checks++; if (busy !== (j <= 3)) begin n_fail++; $display("FAIL flush_busy cycle %0d got %b want %b", j, busy, (j <= 3)); end
            n_checks++; if (flush_done !== (j == 4)) begin
                n_fail++; $display("FAIL flush_done cycle %0d got %b want %b", j, flush_done, (j == 4));
            end
            if (j == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        n_checks++; if (n_fdone != 1) begin n_fail++; $display("FAIL flush_done_count got %0d want 1", n_fdone); end
        n_checks++;
        if (q_id.size() != 2 || q_data[0] !== c_num[5] || q_edge[0] != e0 + 4 ||
            q_data[1] !== c_num[8] || q_edge[1] != e0 + 5 || q_id[0] != 0 || q_id[1] != 0) begin
            n_fail++; $display("FAIL flush_rsp got count %0d want 2 responses 40a00000@%0d 41000000@%0d",
                               q_id.size(), e0 + 4, e0 + 5);
        end
    endtask

    task automatic test_flush_hold();
        n_fdone = 0;
        flush_req = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL empty_drain_ready got %b want 0", req0_ready); end
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL empty_drain_done_early got %b want 0", flush_done); end
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (flush_done !== 1'b1) begin n_fail++; $display("FAIL empty_flush_done got %b want 1", flush_done); end
        repeat (3) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL held_flush_ready got %b want 1", req0_ready); end
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (n_fdone != 1) begin n_fail++; $display("FAIL held_no_reentry got %0d pulses want 1", n_fdone); end
        flush_req = 1'b0;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (n_fdone != 2) begin n_fail++; $display("FAIL rearm_flush got %0d pulses want 2", n_fdone); end
    endtask

    task automatic test_reset_midflight();
        int x0;
        clear_log();
        for (int k = 1; k <= 3; k++) begin
            req0_valid = 1'b1; req0_a = c_num[k]; req0_b = c_num[k];
            @(negedge clk);
        end
        req0_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midflight_busy got %b want 1", busy); end
        rst = 1'b0;
        #1;
        n_checks++; if (add_a !== 32'h0 || add_b !== 32'h0) begin
            n_fail++; $display("FAIL midflight_operands got %h %h want 00000000 00000000", add_a, add_b);
        end
        n_checks++; if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin
            n_fail++; $display("FAIL midflight_rsp_data got %h %h want 00000000 00000000", rsp0_data, rsp1_data);
        end
        n_checks++; if ({rsp0_valid, rsp1_valid, flush_done, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL midflight_flags got %b want 0000", {rsp0_valid, rsp1_valid, flush_done, busy});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = c_num[6]; req0_b = c_num[7];
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", req0_ready); end
        x0 = n_edge + 1;
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++; if (add_a !== c_num[6]) begin n_fail++; $display("FAIL post_reset_operand got %h want %h", add_a, c_num[6]); end
        repeat (8) @(negedge clk);
        n_checks++;
        if (q_id.size() != 1 || q_data[0] !== c_num[13] || q_edge[0] != x0 + 4) begin
            n_fail++; $display("FAIL midflight_discard got %0d responses want only 41500000 at edge %0d",
                               q_id.size(), x0 + 4);
        end
    endtask

    initial begin
        c_num[0]  = 32'h00000000; c_num[1]  = 32'h3F800000; c_num[2]  = 32'h40000000;
        c_num[3]  = 32'h40400000; c_num[4]  = 32'h40800000; c_num[5]  = 32'h40A00000;
        c_num[6]  = 32'h40C00000; c_num[7]  = 32'h40E00000; c_num[8]  = 32'h41000000;
        c_num[9]  = 32'h41100000; c_num[10] = 32'h41200000; c_num[11] = 32'h41300000;
        c_num[12] = 32'h41400000; c_num[13] = 32'h41500000; c_num[14] = 32'h41600000;
        c_num[15] = 32'h41700000; c_num[16] = 32'h41800000; c_num[17] = 32'h41880000;
        c_num[18] = 32'h41900000; c_num[19] = 32'h41980000; c_num[20] = 32'h41A00000;
        test_reset();
        test_contention();
        test_single();
        test_streaming();
        test_flush();
        test_flush_hold();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 3: fixed cycle count from add_a/add_b update to matching add_result, range 1..8.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid, input, 1 and req1_valid, input, 1: requester N has an operand pair pending.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each: IEEE-754 single operands.
REQ-006 SHALL have ports req0_ready, req1_ready, output, 1 each: grant; a transfer occurs on a clock edge where valid and ready are both high.
REQ-007 SHALL have ports add_a, add_b, output, 32 each: registered operands driven to the pipelined adder.
REQ-008 SHALL have port add_result, input, 32: adder output.
REQ-009 SHALL have ports rsp0_valid, rsp1_valid, output, 1 each: one-cycle result strobe to requester N.
REQ-010 SHALL have ports rsp0_data, rsp1_data, output, 32 each: result for requester N.
REQ-011 SHALL have port flush_req, input, 1: request to stop issuing and drain the pipeline.
REQ-012 SHALL have port flush_done, output, 1: one-cycle pulse when the drain completes.
REQ-013 SHALL have port busy, output, 1: high while any issued operation is still in flight.

Function
REQ-014 SHALL implement states RUN and DRAIN.
REQ-015 In RUN, the arbiter SHALL grant at most one requester per cycle using round-robin; the priority pointer SHALL toggle to the other requester only after a completed transfer.
REQ-016 reqN_ready SHALL be combinational: high only in RUN, with reqN_valid high, and either N holds priority or the other requester's valid is low.
REQ-017 On a transfer at edge k, add_a/add_b SHALL load the granted operands at edge k; a tag {valid, id} SHALL enter stage 0 of a LATENCY-deep tag shift register.
REQ-018 Without a transfer, add_a/add_b SHALL hold their values and a zero-valid tag SHALL enter stage 0.
REQ-019 When the final tag stage is valid, add_result SHALL be registered into rspN_data for id N, with rspN_valid high for exactly one cycle; the total latency is LATENCY+1 cycles from the transfer edge to the strobe.
REQ-020 The non-addressed rsp_data SHALL hold its previous value.
REQ-021 Back-to-back transfers every cycle SHALL be supported; results SHALL return in issue order with no loss. There SHALL be no response backpressure.
REQ-022 busy SHALL equal the OR of all valid tag stages.
REQ-023 When flush_req is sampled high in RUN, the next state SHALL be DRAIN; a transfer in that same cycle SHALL still complete.
REQ-024 In DRAIN, both readys SHALL be low and in-flight results SHALL still be delivered.
REQ-025 Exit from DRAIN to RUN SHALL occur on the first edge at which all tag stages are invalid; flush_done SHALL pulse for that one cycle.
REQ-026 flush_req held high after the pulse SHALL NOT re-enter DRAIN until flush_req is sampled low.
REQ-027 flush_req with an empty pipeline SHALL produce DRAIN for one cycle, followed by the flush_done pulse.

Reset
REQ-028 rst low SHALL asynchronously force:
- state to RUN;
- priority to requester 0;
- all tag stages invalid;
- add_a, add_b, rsp0_data and rsp1_data to 0x00000000;
- rsp0_valid, rsp1_valid, flush_done and busy to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results, with no response strobe after reset release.
REQ-030 Reset release SHALL take effect synchronously; the first transfer is possible on the first edge after rst goes high.

Verification
REQ-031 Single request: LATENCY=3, adder model a+b, req0 0x3F800000 + 0x40000000 -> rsp0_valid one cycle, 4 cycles after the transfer edge, rsp0_data=0x40400000.
REQ-032 Contention: both valid for 4 cycles -> grants alternate 0,1,0,1 -> rsp0/rsp1 strobes alternate in the same order, 4 cycles later, with correct sums.
REQ-033 Streaming: req1 valid for 10 consecutive cycles, req0 idle -> 10 transfers, 10 consecutive rsp1 strobes in order, busy high throughout.
REQ-034 Flush: flush_req pulse with 2 operations in flight -> readys low until drained, both responses delivered, flush_done pulses once on the edge where busy falls.
REQ-035 Reset mid-flight: rst low with 3 operations in flight -> all outputs zero immediately, and no response strobe after release.
